// File: rtl/jk_excitation_driver.sv
// Purpose : drives a bank of WIDTH external JK flip-flops to a requested target word,
//           applying J/K excitation for one clock and then reading Q back, retrying on mismatch.
// Latency : accept -> resp_valid is 3 cycles on a clean pass (DRIVE, CHECK, RESP); +2 per retry.
// Backpressure: req_ready is high only in IDLE, so at most one request is in flight;
//           resp_valid is a one-cycle pulse with no response-side stall.
//
// Ports:
//   clk, rst_n            clock (rising edge, shared with the JK bank), async active-low reset
//   req_valid/req_ready   request handshake; target sampled when both are high
//   target[WIDTH]         desired Q word
//   q_fb[WIDTH]           Q outputs of the JK bank
//   j[WIDTH], k[WIDTH]    registered J/K inputs to the bank; 0/0 (hold) outside DRIVE
//   resp_valid            one-cycle completion pulse
//   resp_err              with resp_valid: retries exhausted and readback still mismatches
//   resp_q[WIDTH]         q_fb captured at the final CHECK

module jk_excitation_driver #(
  parameter int WIDTH      = 4,
  parameter bit USE_TOGGLE = 1'b0,
  parameter int MAX_RETRY  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             resp_valid,
  output logic             resp_err,
  output logic [WIDTH-1:0] resp_q
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [2:0] MAX_R = 3'(MAX_RETRY);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] tgt_r, tgt_nxt;
  logic [2:0]       retry_cnt, retry_nxt;
  logic [WIDTH-1:0] j_nxt, k_nxt;
  logic             resp_valid_nxt, resp_err_nxt;
  logic [WIDTH-1:0] resp_q_nxt;

  // Per-bit excitation: bits already at target get the hold code (0,0); bits
  // that must change get either set/reset or toggle depending on USE_TOGGLE.
  // Returned as {j, k}.
  function automatic logic [2*WIDTH-1:0] excite(input logic [WIDTH-1:0] q,
                                                input logic [WIDTH-1:0] t);
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] jj;
    logic [WIDTH-1:0] kk;
    diff = q ^ t;
    if (USE_TOGGLE) begin
      jj = diff;
      kk = diff;
    end else begin
      jj = diff & t;
      kk = diff & ~t;
    end
    return {jj, kk};
  endfunction

  assign req_ready = (state == IDLE);

  always_comb begin
    state_nxt      = state;
    tgt_nxt        = tgt_r;
    retry_nxt      = retry_cnt;
    j_nxt          = '0;
    k_nxt          = '0;
    resp_valid_nxt = 1'b0;
    resp_err_nxt   = 1'b0;
    resp_q_nxt     = resp_q;

    case (state)
      IDLE: begin
        if (req_valid) begin
          // tgt_r only updates on this edge, so excitation uses target directly.
          tgt_nxt        = target;
          retry_nxt      = '0;
          {j_nxt, k_nxt} = excite(q_fb, target);
          state_nxt      = DRIVE;
        end
      end

      DRIVE: begin
        // j/k return to hold on the edge where the bank consumes them.
        state_nxt = CHECK;
      end

      CHECK: begin
        resp_q_nxt = q_fb;
        if (q_fb == tgt_r) begin
          resp_valid_nxt = 1'b1;
          resp_err_nxt   = 1'b0;
          state_nxt      = RESP;
        end else if (retry_cnt < MAX_R) begin
          // Recompute from the observed Q so partially-applied bits are not
          // toggled back in toggle mode.
          retry_nxt      = retry_cnt + 3'd1;
          {j_nxt, k_nxt} = excite(q_fb, tgt_r);
          state_nxt      = DRIVE;
        end else begin
          resp_valid_nxt = 1'b1;
          resp_err_nxt   = 1'b1;
          state_nxt      = RESP;
        end
      end

      RESP: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tgt_r      <= '0;
      retry_cnt  <= '0;
      j          <= '0;
      k          <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_q     <= '0;
    end else begin
      state      <= state_nxt;
      tgt_r      <= tgt_nxt;
      retry_cnt  <= retry_nxt;
      j          <= j_nxt;
      k          <= k_nxt;
      resp_valid <= resp_valid_nxt;
      resp_err   <= resp_err_nxt;
      resp_q     <= resp_q_nxt;
    end
  end

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Purpose : self-checking bench for jk_excitation_driver, set/reset (inst 0) and toggle (inst 1) coding.
// Latency : expects 3 cycles per clean pass, +2 per retry.
// Backpressure: holds req_valid until the DUT's IDLE accepts; responses are scoreboarded.

module tb_jk_excitation_driver;

  typedef struct packed {
    logic       err;
    logic [3:0] q;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid [2];
  logic       req_ready [2];
  logic [3:0] target    [2];
  logic [3:0] q_fb      [2];
  logic [3:0] j         [2];
  logic [3:0] k         [2];
  logic       resp_valid[2];
  logic       resp_err  [2];
  logic [3:0] resp_q    [2];
  logic [3:0] stuck0    [2];
  logic       prev_vld  [2];

  exp_t sb0[$];
  exp_t sb1[$];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  jk_excitation_driver #(.WIDTH(4), .USE_TOGGLE(1'b0), .MAX_RETRY(2)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .target(target[0]),
    .q_fb(q_fb[0]), .j(j[0]), .k(k[0]),
    .resp_valid(resp_valid[0]), .resp_err(resp_err[0]), .resp_q(resp_q[0])
  );

  jk_excitation_driver #(.WIDTH(4), .USE_TOGGLE(1'b1), .MAX_RETRY(2)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .target(target[1]),
    .q_fb(q_fb[1]), .j(j[1]), .k(k[1]),
    .resp_valid(resp_valid[1]), .resp_err(resp_err[1]), .resp_q(resp_q[1])
  );

  // Ideal JK bank; bits set in stuck0 are forced to 0. Not reset by rst_n.
  function automatic logic [3:0] jk_next(input logic [3:0] q, input logic [3:0] jj,
                                         input logic [3:0] kk);
    logic [3:0] n;
    for (int b = 0; b < 4; b++) begin
      case ({jj[b], kk[b]})
        2'b00:   n[b] = q[b];
        2'b10:   n[b] = 1'b1;
        2'b01:   n[b] = 1'b0;
        default: n[b] = ~q[b];
      endcase
    end
    return n;
  endfunction

  initial begin
    q_fb[0] = 4'b0000;
    q_fb[1] = 4'b0000;
  end

  always @(posedge clk) begin
    q_fb[0] <= jk_next(q_fb[0], j[0], k[0]) & ~stuck0[0];
    q_fb[1] <= jk_next(q_fb[1], j[1], k[1]) & ~stuck0[1];
  end

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Response monitor: pops the scoreboard on every resp_valid.
  always @(negedge clk) begin
    exp_t e;
    if (resp_valid[0]) begin
      chk("resp_pulse0", {7'd0, prev_vld[0]}, 8'd0);
      if (sb0.size() == 0) chk("unexpected_resp0", 8'd1, 8'd0);
      else begin
        e = sb0.pop_front();
        chk("resp_err0", {7'd0, resp_err[0]}, {7'd0, e.err});
        chk("resp_q0", {4'd0, resp_q[0]}, {4'd0, e.q});
      end
    end
    if (resp_valid[1]) begin
      chk("resp_pulse1", {7'd0, prev_vld[1]}, 8'd0);
      if (sb1.size() == 0) chk("unexpected_resp1", 8'd1, 8'd0);
      else begin
        e = sb1.pop_front();
        chk("resp_err1", {7'd0, resp_err[1]}, {7'd0, e.err});
        chk("resp_q1", {4'd0, resp_q[1]}, {4'd0, e.q});
      end
    end
    prev_vld[0] = resp_valid[0];
    prev_vld[1] = resp_valid[1];
  end

  function automatic void push_exp(input int sel, input logic err, input logic [3:0] q);
    exp_t e;
    e.err = err;
    e.q   = q;
    if (sel == 1) sb1.push_back(e);
    else          sb0.push_back(e);
  endfunction

  // One request; every DRIVE cycle is expected to carry (exp_j, exp_k).
  task automatic run_req(input int sel, input logic [3:0] tgt, input logic [3:0] exp_j,
                         input logic [3:0] exp_k, input int drives, input logic exp_err,
                         input logic [3:0] exp_q);
    int got_lat;
    int lat;
    got_lat = 0;
    lat = 1 + 2 * drives;
    @(negedge clk);
    chk("ready_idle", {7'd0, req_ready[sel]}, 8'd1);
    req_valid[sel] = 1'b1;
    target[sel]    = tgt;
    push_exp(sel, exp_err, exp_q);
    @(posedge clk);
    #1;
    req_valid[sel] = 1'b0;
    target[sel]    = ~tgt;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      chk("ready_busy", {7'd0, req_ready[sel]}, 8'd0);
      if (resp_valid[sel]) begin
        got_lat = c;
        chk("j_resp", {4'd0, j[sel]}, 8'd0);
        chk("k_resp", {4'd0, k[sel]}, 8'd0);
        break;
      end
      if (c % 2 == 1) begin
        chk("j_drive", {4'd0, j[sel]}, {4'd0, exp_j});
        chk("k_drive", {4'd0, k[sel]}, {4'd0, exp_k});
      end else begin
        chk("j_check", {4'd0, j[sel]}, 8'd0);
        chk("k_check", {4'd0, k[sel]}, 8'd0);
      end
    end
    if (got_lat == 0) chk("resp_timeout", 8'd0, 8'd1);
    else              chk("latency", 8'(got_lat), 8'(lat));
  endtask

  initial begin
    req_valid[0] = 1'b0; req_valid[1] = 1'b0;
    target[0] = 4'd0;    target[1] = 4'd0;
    stuck0[0] = 4'd0;    stuck0[1] = 4'd0;
    prev_vld[0] = 1'b0;  prev_vld[1] = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk("rst_ready", {7'd0, req_ready[s]}, 8'd1);
      chk("rst_j", {4'd0, j[s]}, 8'd0);
      chk("rst_k", {4'd0, k[s]}, 8'd0);
      chk("rst_vld", {7'd0, resp_valid[s]}, 8'd0);
      chk("rst_err", {7'd0, resp_err[s]}, 8'd0);
      chk("rst_q", {4'd0, resp_q[s]}, 8'd0);
    end
    rst_n = 1'b1;

    // Set/reset coding: 0000 -> 1010
    run_req(0, 4'b1010, 4'b1010, 4'b0000, 1, 1'b0, 4'b1010);
    // Toggle coding: 0000 -> 1010 -> 0110, then same-target pass
    run_req(1, 4'b1010, 4'b1010, 4'b1010, 1, 1'b0, 4'b1010);
    run_req(1, 4'b0110, 4'b1100, 4'b1100, 1, 1'b0, 4'b0110);
    run_req(1, 4'b0110, 4'b0000, 4'b0000, 1, 1'b0, 4'b0110);
    chk("bank1_unchanged", {4'd0, q_fb[1]}, 8'b0110);

    // Back-to-back: req_valid held, 1111 then 0000 (target changes are ignored mid-transaction)
    @(negedge clk);
    req_valid[0] = 1'b1;
    target[0]    = 4'b1111;
    push_exp(0, 1'b0, 4'b1111);
    push_exp(0, 1'b0, 4'b0000);
    @(posedge clk);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) begin
        target[0] = 4'b0000;
        chk("b2b_j1", {4'd0, j[0]}, 8'b0101);
        chk("b2b_k1", {4'd0, k[0]}, 8'b0000);
      end
      if (c <= 4) chk("b2b_ready", {7'd0, req_ready[0]}, {7'd0, c == 4});
      if (c == 3 || c == 7) chk("b2b_vld", {7'd0, resp_valid[0]}, 8'd1);
      if (c == 5) begin
        req_valid[0] = 1'b0;
        chk("b2b_j2", {4'd0, j[0]}, 8'b0000);
        chk("b2b_k2", {4'd0, k[0]}, 8'b1111);
      end
    end

    // Bit 0 stuck at 0: three drives, then error
    stuck0[0] = 4'b0001;
    run_req(0, 4'b0001, 4'b0001, 4'b0000, 3, 1'b1, 4'b0000);
    stuck0[0] = 4'b0000;

    // Reset asserted during DRIVE
    @(negedge clk);
    req_valid[0] = 1'b1;
    target[0]    = 4'b1111;
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("abort_j_drive", {4'd0, j[0]}, 8'b1111);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_j_async", {4'd0, j[0]}, 8'd0);
    chk("abort_k_async", {4'd0, k[0]}, 8'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("abort_ready", {7'd0, req_ready[0]}, 8'd1);
    chk("abort_bank_hold", {4'd0, q_fb[0]}, 8'd0);

    repeat (3) @(negedge clk);
    chk("sb0_empty", 8'(sb0.size()), 8'd0);
    chk("sb1_empty", 8'(sb1.size()), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
